// File: rtl/prime_stream_pkg.sv
// Shared types for the prime stream consumer.
//   state_e : 3-bit FSM state encoding used by prime_stream.
package prime_stream_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQUEST = 3'd1,
      ST_GUARD   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/prime_fifo.sv
// Synchronous first-word-fall-through FIFO holding generated primes.
// Ports:
//   clk, rst       clock, synchronous active-high reset (empties the FIFO)
//   push, din      write strobe and data (ignored while full)
//   pop            read strobe (ignored while empty)
//   dout           head entry, valid while !empty
//   empty, full    occupancy flags decoded from the registered occupancy
module prime_fifo #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned DEPTH_LOG = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG;
   localparam int unsigned OW    = DEPTH_LOG + 1;

   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
   logic [OW-1:0]        occ_q, occ_d;
   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic                 push_en;
   logic                 pop_en;

   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
      case ({push_en, pop_en})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Storage needs no reset; contents are only visible when !empty.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign empty = (occ_q == '0);
   assign full  = (occ_q == OW'(DEPTH));

endmodule

// File: rtl/prime_stream.sv
// Consumer of the prime generator: requests primes one at a time, buffers
// them in a FWFT FIFO and presents them as a valid/ready stream. Stops for
// good when the generator reports overflow.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start                         begin collection (honoured in IDLE only)
//   gen_go                        request pulse to the generator
//   gen_ready, gen_error, gen_res generator response
//   out_valid, out_ready, out_data  output stream (FIFO head)
//   count                         primes pushed, saturating
//   overflow                      sticky generator error
//   done                          finished and FIFO drained
// Build option: PRIME_STREAM_EMIT_ONE_EN pushes the generator's initial
// value (1) on start so it becomes the first stream element.
module prime_stream
   import prime_stream_pkg::*;
#(
   parameter int unsigned WIDTH_LOG = 4,
   parameter int unsigned DEPTH_LOG = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      gen_go,
   input  logic                      gen_ready,
   input  logic                      gen_error,
   input  logic [(1<<WIDTH_LOG)-1:0] gen_res,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [(1<<WIDTH_LOG)-1:0] out_data,
   output logic [(1<<WIDTH_LOG)-1:0] count,
   output logic                      overflow,
   output logic                      done
);

   localparam int unsigned WIDTH = 1 << WIDTH_LOG;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push;
   logic             fifo_empty;
   logic             fifo_full;

   // State and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state logic; REQUEST waits for FIFO space so the single
   // outstanding request always has a slot to land in.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_REQUEST;
         ST_REQUEST: if (!fifo_full) state_d = ST_GUARD;
         ST_GUARD:   state_d = ST_WAIT;
         ST_WAIT: begin
            if (gen_error)      state_d = ST_DONE;
            else if (gen_ready) state_d = ST_REQUEST;
         end
         ST_DONE:    state_d = ST_DONE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output/datapath decode; error takes priority over ready in WAIT.
   always_comb begin
      push       = 1'b0;
      overflow_d = overflow_q;
      if (state_q == ST_WAIT) begin
         if (gen_error)      overflow_d = 1'b1;
         else if (gen_ready) push       = 1'b1;
      end
`ifdef PRIME_STREAM_EMIT_ONE_EN
      if ((state_q == ST_IDLE) && start) push = 1'b1;
`else
`endif
      count_d = count_q;
      if (push && (count_q != '1)) count_d = count_q + WIDTH'(1);
   end

   prime_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (gen_res),
      .pop   (out_valid && out_ready),
      .dout  (out_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Decodes of registered state only; no input-to-output paths.
   assign gen_go    = (state_q == ST_REQUEST) && !fifo_full;
   assign out_valid = !fifo_empty;
   assign done      = (state_q == ST_DONE) && fifo_empty;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_prime_stream.sv
// Self-checking bench for prime_stream with a behavioural prime generator
// (WIDTH_LOG = 3, so the generator overflows after 251).
module tb_prime_stream;

   localparam int unsigned WIDTH_LOG = 3;
   localparam int unsigned DEPTH_LOG = 2;
   localparam int unsigned WIDTH     = 1 << WIDTH_LOG;
`ifdef PRIME_STREAM_EMIT_ONE_EN
   localparam int EMIT = 1;
`else
   localparam int EMIT = 0;
`endif

   logic             clk;
   logic             rst;
   logic             start;
   logic             gen_go;
   logic             gen_ready;
   logic             gen_error;
   logic [WIDTH-1:0] gen_res;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [WIDTH-1:0] count;
   logic             overflow;
   logic             done;

   int checks   = 0;
   int failures = 0;
   int popped[$];
   int exp_s[$];
   int go_cnt = 0;
   int g_cnt;
   logic g_busy;

   typedef struct {
      string name;
      int    exp;
   } vec_t;
   vec_t t1[6];

   prime_stream #(
      .WIDTH_LOG (WIDTH_LOG),
      .DEPTH_LOG (DEPTH_LOG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .gen_go    (gen_go),
      .gen_ready (gen_ready),
      .gen_error (gen_error),
      .gen_res   (gen_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic bit is_prime(int n);
      if (n < 2) return 1'b0;
      for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int next_prime(int cur);
      for (int n = cur + 1; n < (1 << WIDTH); n++) if (is_prime(n)) return n;
      return 0;
   endfunction

   // Behavioural generator: res = 1 and ready = 1 after reset; go drops
   // ready, a few cycles later reports the next prime or error.
   always @(posedge clk) begin
      int nxt;
      if (rst) begin
         gen_res   <= WIDTH'(1);
         gen_ready <= 1'b1;
         gen_error <= 1'b0;
         g_busy    <= 1'b0;
         g_cnt     <= 0;
      end else if (gen_go) begin
         gen_ready <= 1'b0;
         g_busy    <= 1'b1;
         g_cnt     <= 2;
      end else if (g_busy) begin
         if (g_cnt != 0) g_cnt <= g_cnt - 1;
         else begin
            g_busy <= 1'b0;
            nxt = next_prime(int'(gen_res));
            if (nxt == 0) gen_error <= 1'b1;
            else begin
               gen_res   <= WIDTH'(nxt);
               gen_ready <= 1'b1;
            end
         end
      end
   end

   // Stream and request monitor.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) popped.push_back(int'(out_data));
      if (!rst && gen_go) go_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_pops(input int n, input int budget);
      int c = 0;
      while (popped.size() < n && c < budget) begin @(negedge clk); c++; end
      check("wait_pops", int'(popped.size() >= n), 1);
   endtask

   task automatic wait_count(input int n, input int budget);
      int c = 0;
      while (int'(count) < n && c < budget) begin @(negedge clk); c++; end
      check("wait_count", int'(count), n);
   endtask

   task automatic wait_ready(input logic v, input int budget);
      int c = 0;
      while (gen_ready !== v && c < budget) begin @(negedge clk); c++; end
      check("wait_ready", int'(gen_ready), int'(v));
   endtask

   initial begin
      int base_pop;
      int base_go;
      int c;

      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      if (EMIT != 0) exp_s.push_back(1);
      for (int n = 2; n < (1 << WIDTH); n++) if (is_prime(n)) exp_s.push_back(n);

`ifdef PRIME_STREAM_EMIT_ONE_EN
      t1[0] = '{"s0", 1};  t1[1] = '{"s1", 2};  t1[2] = '{"s2", 3};
      t1[3] = '{"s3", 5};  t1[4] = '{"s4", 7};  t1[5] = '{"s5", 11};
`else
      t1[0] = '{"s0", 2};  t1[1] = '{"s1", 3};  t1[2] = '{"s2", 5};
      t1[3] = '{"s3", 7};  t1[4] = '{"s4", 11}; t1[5] = '{"s5", 13};
`endif

      // Reset state, then a free-flowing stream.
      do_reset();
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_count", int'(count), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_done", int'(done), 0);
      check("rst_gen_go", int'(gen_go), 0);
      base_pop = popped.size();
      out_ready = 1'b1;
      pulse_start();
      wait_pops(base_pop + 6, 400);
      check("stream_count6", int'(count), 6);
      for (int i = 0; i < 6; i++)
         check(t1[i].name, (base_pop + i < popped.size()) ? popped[base_pop + i] : -1, t1[i].exp);

      // Backpressure: FIFO fills, requests stop, one pop lets one through.
      do_reset();
      base_pop = popped.size();
      base_go  = go_cnt;
      pulse_start();
      repeat (80) @(negedge clk);
      check("full_go_cnt", go_cnt - base_go, 4 - EMIT);
      check("full_count", int'(count), 4);
      check("full_valid", int'(out_valid), 1);
      check("full_head", int'(out_data), exp_s[0]);
      check("full_gen_go", int'(gen_go), 0);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (40) @(negedge clk);
      check("pop1_go_cnt", go_cnt - base_go, 5 - EMIT);
      check("pop1_count", int'(count), 5);
      check("pop1_pops", popped.size() - base_pop, 1);
      check("pop1_head", int'(out_data), exp_s[1]);
      out_ready = 1'b1;
      wait_pops(base_pop + 5, 200);
      for (int i = 0; i < 5; i++)
         check("bp_order", (base_pop + i < popped.size()) ? popped[base_pop + i] : -1, exp_s[i]);

      // Push and pop on the same edge with two entries buffered.
      do_reset();
      base_pop = popped.size();
      pulse_start();
      wait_count(2, 200);
      wait_ready(1'b0, 50);
      wait_ready(1'b1, 50);
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(negedge clk);
      check("sim_count", int'(count), 3);
      check("sim_pops", popped.size() - base_pop, 1);
      check("sim_head", int'(out_data), exp_s[1]);
      repeat (80) @(negedge clk);
      check("sim_fill_count", int'(count), 5);
      out_ready = 1'b1;
      wait_pops(base_pop + 5, 200);
      for (int i = 0; i < 5; i++)
         check("sim_order", (base_pop + i < popped.size()) ? popped[base_pop + i] : -1, exp_s[i]);

      // Run until the generator overflows.
      do_reset();
      base_pop = popped.size();
      out_ready = 1'b1;
      pulse_start();
      c = 0;
      while (done !== 1'b1 && c < 5000) begin @(negedge clk); c++; end
      check("ovf_done", int'(done), 1);
      check("ovf_overflow", int'(overflow), 1);
      check("ovf_n_pops", popped.size() - base_pop, exp_s.size());
      check("ovf_count", int'(count), exp_s.size());
      check("ovf_last", (popped.size() > 0) ? popped[popped.size() - 1] : -1, 251);
      c = 0;
      for (int i = 0; i < exp_s.size() && base_pop + i < popped.size(); i++)
         if (popped[base_pop + i] != exp_s[i]) c++;
      check("ovf_order_errs", c, 0);
      base_go = go_cnt;
      pulse_start();
      repeat (20) @(negedge clk);
      check("done_start_go", go_cnt - base_go, 0);
      check("done_hold", int'(done), 1);
      check("done_valid", int'(out_valid), 0);

      // Reset while waiting on the generator, then restart.
      do_reset();
      pulse_start();
      wait_count(2, 200);
      wait_ready(1'b0, 50);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("wrst_valid", int'(out_valid), 0);
      check("wrst_count", int'(count), 0);
      check("wrst_overflow", int'(overflow), 0);
      check("wrst_gen_go", int'(gen_go), 0);
      rst = 1'b0;
      base_pop = popped.size();
      out_ready = 1'b1;
      pulse_start();
      wait_pops(base_pop + 3, 200);
      for (int i = 0; i < 3; i++)
         check("wrst_order", (base_pop + i < popped.size()) ? popped[base_pop + i] : -1, exp_s[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
